// File: rtl/lu_serial_ctrl.sv
// Bit-serial sequencer that streams W-bit logic operations through a 1-bit logic unit,
// LSB first, and returns the assembled result on a valid/ready port.
module lu_serial_ctrl #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [W-1:0] cmd_a,
   input  logic [W-1:0] cmd_b,
   output logic         lu_s0,
   output logic         lu_s1,
   output logic         lu_x,
   output logic         lu_y,
   input  logic         lu_f,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] res_data,
   output logic         busy
);

   localparam int unsigned CW = $clog2(W);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e         state_q, state_d;
   logic [1:0]     op_q, op_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   r_q, r_d;
   logic [W-1:0]   res_q, res_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   r_shift;
   logic           last_bit;

   // Incoming F3 bit enters at the MSB so after W shifts bit 0 holds the first result bit.
   assign r_shift  = {lu_f, r_q[W-1:1]};
   assign last_bit = (cnt_q == CW'(W - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               op_d    = cmd_op;
               a_d     = cmd_a;
               b_d     = cmd_b;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            r_d = r_shift;
            a_d = a_q >> 1;
            b_d = b_q >> 1;
            if (last_bit) begin
               res_d   = r_shift;
               cnt_d   = '0;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StDone: begin
            if (res_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      res_valid = 1'b0;
      busy      = 1'b1;
      lu_s0     = 1'b0;
      lu_s1     = 1'b0;
      lu_x      = 1'b0;
      lu_y      = 1'b0;
      unique case (state_q)
         StIdle: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         StRun: begin
            lu_s1 = op_q[1];
            lu_s0 = op_q[0];
            lu_x  = a_q[0];
            lu_y  = b_q[0];
         end
         StDone:  res_valid = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   assign res_data = res_q;

endmodule

// File: tb/tb_lu_serial_ctrl.sv
// Scoreboard bench for lu_serial_ctrl: directed and random ops against a word-level
// reference; a negedge monitor pops expected results on each result handshake.
`timescale 1ns/1ps
module tb_lu_serial_ctrl;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst_n;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [W-1:0] cmd_a;
   logic [W-1:0] cmd_b;
   logic         lu_s0, lu_s1, lu_x, lu_y, lu_f;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] res_data;
   logic         busy;

   int vectors     = 0;
   int miscompares = 0;
   logic [W-1:0] sb_q[$];
   logic [W-1:0] mon_exp;

   lu_serial_ctrl #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .lu_s0     (lu_s0),
      .lu_s1     (lu_s1),
      .lu_x      (lu_x),
      .lu_y      (lu_y),
      .lu_f      (lu_f),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .busy      (busy)
   );

   // Behavioural 1-bit logic unit.
   always_comb begin
      case ({lu_s1, lu_s0})
         2'b00:   lu_f = lu_x & lu_y;
         2'b01:   lu_f = lu_x | lu_y;
         2'b10:   lu_f = ~lu_x;
         default: lu_f = lu_x ^ lu_y;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return ~a;
         default: return a ^ b;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_result: got %0h expected none", res_data);
         end else begin
            mon_exp = sb_q.pop_front();
            check("res_data", 32'(res_data), 32'(mon_exp));
         end
      end
   end

   // Presents a command and returns once it has been accepted (just after the accept edge).
   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output longint t_acc);
      int n;
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         $display("FAIL cmd_ready_timeout: got 0 expected 1");
         $fatal(1, "cmd_ready never asserted");
      end
      @(posedge clk);
      t_acc = longint'($time);
      sb_q.push_back(ref_op(op, a, b));
   endtask

   // Full operation: latency, select stability, X bit order, optional result stall.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int stall);
      longint t0;
      int n;
      int sel_bad;
      logic [W-1:0] xs;
      issue(op, a, b, t0);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_a     = W'($urandom);
      cmd_b     = W'($urandom);
      res_ready = (stall == 0);
      n = 0;
      sel_bad = 0;
      xs = '0;
      @(negedge clk);
      while (!res_valid && n < 40) begin
         if (n < W) xs[n] = lu_x;
         if ({lu_s1, lu_s0} !== op || busy !== 1'b1 || cmd_ready !== 1'b0) sel_bad++;
         @(negedge clk);
         n++;
      end
      check("latency", 32'(n), 32'(W));
      check("x_sequence", 32'(xs), 32'(a));
      check("run_outputs", 32'(sel_bad), 32'd0);
      if (stall > 0) begin
         for (int i = 0; i < stall; i++) begin
            if (i > 0) @(negedge clk);
            check("hold_data", 32'(res_data), 32'(ref_op(op, a, b)));
            check("hold_flags", {res_valid, cmd_ready, busy}, 3'b101);
         end
         @(posedge clk);
         #1;
         res_ready = 1'b1;
         @(negedge clk);
      end
      @(negedge clk);
      check("back_to_idle", {res_valid, cmd_ready, busy}, 3'b010);
      check("done_lu_zero", {lu_s1, lu_s0, lu_x, lu_y}, 4'b0000);
   endtask

   initial begin
      longint t1, t2;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_a     = '0;
      cmd_b     = '0;
      res_ready = 1'b1;
      #12;
      check("rst_flags", {cmd_ready, res_valid, busy}, 3'b100);
      check("rst_lu", {lu_s1, lu_s0, lu_x, lu_y}, 4'b0000);
      check("rst_data", 32'(res_data), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_op(2'd0, 8'hA5, 8'h3C, 0);
      run_op(2'd1, 8'hA5, 8'h3C, 0);
      run_op(2'd2, 8'hA5, 8'hFF, 0);
      run_op(2'd3, 8'hA5, 8'h3C, 0);
      run_op(2'd3, 8'hFF, 8'h0F, 5);

      // Back-to-back with cmd_valid held high throughout.
      issue(2'd0, 8'hF0, 8'hFF, t1);
      issue(2'd1, 8'h01, 8'h80, t2);
      check("b2b_spacing", 32'((t2 - t1) / 10), 32'(W + 2));
      #1;
      cmd_valid = 1'b0;
      repeat (W + 4) @(negedge clk);
      check("b2b_drained", 32'(sb_q.size()), 32'd0);

      for (int i = 0; i < 20; i++) begin
         run_op(2'($urandom), W'($urandom), W'($urandom),
                (i % 3 == 0) ? int'($urandom_range(1, 4)) : 0);
      end

      // Asynchronous reset in the middle of an OR operation.
      issue(2'd1, 8'h5A, 8'h81, t1);
      #1;
      cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_flags", {cmd_ready, res_valid, busy}, 3'b100);
      check("async_rst_lu", {lu_s1, lu_s0, lu_x, lu_y}, 4'b0000);
      check("async_rst_data", 32'(res_data), 32'd0);
      sb_q.delete();
      #2;
      rst_n = 1'b1;
      run_op(2'd0, 8'h0F, 8'h03, 0);

      repeat (4) @(negedge clk);
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
